// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Fetch FSM encodings, the NOP bubble word and the IF/ID bundle.
package instr_fetch_stage_pkg;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds.
// Flush turns the slot into a NOP bubble but keeps the PC.
module instr_fetch_stage_if_id_reg
    import instr_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t din,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '{instr: INSTR_NOP, pc: 32'd0, valid: 1'b0};
        end else if (flush) begin
            q.instr <= INSTR_NOP;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= din;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// RV32I fetch stage: PcF, one-outstanding imem handshake, IF/ID register.
// Define IF_PERF_CNT_EN to add fetch_cnt / redirect_cnt counters.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            JalD,
    input  logic [XLEN-1:0] JalTargetD,
    input  logic            BrRedirectE,
    input  logic [XLEN-1:0] BrTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic            ValidD
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0]     fetch_cnt,
    output logic [31:0]     redirect_cnt
`endif
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] hold;
    logic            redir;
    logic [XLEN-1:0] tgt;
    logic            ld;
    if_id_t          ld_d;
    if_id_t          ifid_q;

    always_comb begin
        redir = BrRedirectE | JalD;
        tgt   = BrRedirectE ? BrTargetE : JalTargetD;
        ld    = !redir && !StallD &&
                ((state == S_WAIT && imem_rvalid) || state == S_HOLD);
        ld_d  = '{instr: (state == S_HOLD) ? hold : imem_rdata,
                  pc:    pc_f,
                  valid: 1'b1};
    end

    // A redirect never loads IF/ID; an in-flight request becomes stale (DROP).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc_f     <= RESET_PC;
            hold     <= '0;
            imem_req <= 1'b0;
        end else if (redir) begin
            pc_f <= tgt;
            hold <= '0;
            unique case (state)
                S_REQ: begin
                    state    <= imem_ready ? S_DROP : S_REQ;
                    imem_req <= !imem_ready;
                end
                S_WAIT, S_DROP: begin
                    state    <= imem_rvalid ? S_REQ : S_DROP;
                    imem_req <= imem_rvalid;
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end else begin
            unique case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && StallD) begin
                        hold  <= imem_rdata;
                        state <= S_HOLD;
                    end else if (imem_rvalid) begin
                        pc_f     <= pc_f + 32'd4;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        pc_f     <= pc_f + 32'd4;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    instr_fetch_stage_if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (ld),
        .flush (FlushD),
        .din   (ld_d),
        .q     (ifid_q)
    );

    assign imem_addr = pc_f;
    assign InstrD    = ifid_q.instr;
    assign PCD       = ifid_q.pc;
    assign ValidD    = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt    <= 32'd0;
            redirect_cnt <= 32'd0;
        end else begin
            if (ld && !FlushD)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (redir)
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed table, reset sequence, random run.
// Counter checks are active when IF_PERF_CNT_EN is defined.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD, FlushD, JalD, BrRedirectE;
    logic [31:0] JalTargetD, BrTargetE;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD;
    logic        ValidD;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, redirect_cnt;
`endif

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .JalD        (JalD),
        .JalTargetD  (JalTargetD),
        .BrRedirectE (BrRedirectE),
        .BrTargetE   (BrTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .ValidD      (ValidD)
`ifdef IF_PERF_CNT_EN
       ,.fetch_cnt   (fetch_cnt),
        .redirect_cnt(redirect_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_req,
                           input logic [31:0] e_addr, input logic [31:0] e_instr,
                           input logic [31:0] e_pcd, input logic e_valid);
        chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".addr"},  imem_addr, e_addr);
        chk({tag, ".instr"}, InstrD, e_instr);
        chk({tag, ".pcd"},   PCD, e_pcd);
        chk({tag, ".valid"}, {31'd0, ValidD}, {31'd0, e_valid});
    endtask

    task automatic idle_inputs();
        StallD = 0; FlushD = 0; JalD = 0; BrRedirectE = 0;
        JalTargetD = 0; BrTargetE = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    endtask

    function automatic logic [31:0] wordf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] rtgt();
        unique case ($urandom % 8)
            0: return $urandom;
            1: return 32'hFFFF_FFF8;
            default: return $urandom & 32'h0000_3FFC;
        endcase
    endfunction

    typedef struct {
        logic        ready, rvalid;
        logic [31:0] rdata;
        logic        stall, flush, jal;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pcd;
        logic        e_valid;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model for the random run: request/response bookkeeping.
    logic        m_started, m_busy, m_stale, m_hv;
    logic [31:0] m_pc, m_hw, m_instr, m_pcd;
    logic        m_valid;
    logic [31:0] m_fc, m_rc;

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_stale = 0; m_hv = 0;
        m_pc = 32'h0; m_hw = 0;
        m_instr = NOP; m_pcd = 0; m_valid = 0;
        m_fc = 0; m_rc = 0;
    endtask

    task automatic model_step();
        logic        req, acc, resp, redir, ld;
        logic [31:0] tgt, w;
        req   = m_started && !m_busy && !m_hv;
        acc   = req && imem_ready;
        resp  = m_busy && imem_rvalid;
        redir = BrRedirectE || JalD;
        tgt   = BrRedirectE ? BrTargetE : JalTargetD;
        ld    = 0;
        w     = 0;
        m_started = 1;
        if (redir) begin
            m_hv = 0;
            if (acc) begin
                m_busy = 1; m_stale = 1;
            end else if (resp) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_stale = 1;
            end
        end else if (acc) begin
            m_busy = 1; m_stale = 0;
        end else if (resp) begin
            m_busy = 0;
            if (!m_stale) begin
                if (StallD) begin
                    m_hv = 1; m_hw = imem_rdata;
                end else begin
                    ld = 1; w = imem_rdata;
                end
            end
        end else if (m_hv && !StallD) begin
            m_hv = 0; ld = 1; w = m_hw;
        end
        if (FlushD) begin
            m_instr = NOP; m_valid = 0;
        end else if (ld) begin
            m_instr = w; m_pcd = m_pc; m_valid = 1;
        end
        if (ld && !FlushD) m_fc = m_fc + 1;
        if (redir) m_rc = m_rc + 1;
        if (redir) m_pc = tgt;
        else if (ld) m_pc = m_pc + 32'd4;
    endtask

    task automatic fetch_one(input logic [31:0] a, input int k);
        int n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("rf%0d.req_seen", k), {31'd0, imem_req}, 32'd1);
        chk($sformatf("rf%0d.addr", k), imem_addr, a);
        imem_ready = 1;
        @(negedge clk);
        imem_ready = 0;
        imem_rvalid = 1;
        imem_rdata = wordf(a);
        @(negedge clk);
        imem_rvalid = 0;
        chk($sformatf("rf%0d.instr", k), InstrD, wordf(a));
        chk($sformatf("rf%0d.pcd", k), PCD, a);
        chk($sformatf("rf%0d.valid", k), {31'd0, ValidD}, 32'd1);
    endtask

    initial begin
        logic        mpend, acc_mem;
        int          mcnt;
        logic [31:0] maddr, saddr;

        //        rdy rv rdata          st fl jal jt          br bt            req addr           instr          pcd            v
        tbl.push_back('{0,0,32'h0,          0,0,0,32'h0,       0,32'h0,         0,32'h0,         NOP,           32'h0,         0});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'h0,         NOP,           32'h0,         0});
        tbl.push_back('{0,1,32'h0010_0093,  0,0,0,32'h0,       0,32'h0,         0,32'h0,         NOP,           32'h0,         0});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'h4,         32'h0010_0093, 32'h0,         1});
        tbl.push_back('{0,1,32'h0020_0093,  0,0,0,32'h0,       0,32'h0,         0,32'h4,         32'h0010_0093, 32'h0,         1});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'h8,         32'h0020_0093, 32'h4,         1});
        tbl.push_back('{0,1,32'h0030_0093,  1,0,0,32'h0,       0,32'h0,         0,32'h8,         32'h0020_0093, 32'h4,         1});
        tbl.push_back('{0,0,32'h0,          1,0,0,32'h0,       0,32'h0,         0,32'h8,         32'h0020_0093, 32'h4,         1});
        tbl.push_back('{0,0,32'h0,          1,0,0,32'h0,       0,32'h0,         0,32'h8,         32'h0020_0093, 32'h4,         1});
        tbl.push_back('{0,0,32'h0,          0,0,0,32'h0,       0,32'h0,         0,32'h8,         32'h0020_0093, 32'h4,         1});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'hC,         32'h0030_0093, 32'h8,         1});
        tbl.push_back('{0,0,32'h0,          0,1,0,32'h0,       1,32'h100,       0,32'hC,         32'h0030_0093, 32'h8,         1});
        tbl.push_back('{0,0,32'h0,          0,0,0,32'h0,       0,32'h0,         0,32'h100,       NOP,           32'h8,         0});
        tbl.push_back('{0,1,32'hBAD0_0093,  0,0,0,32'h0,       0,32'h0,         0,32'h100,       NOP,           32'h8,         0});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'h100,       NOP,           32'h8,         0});
        tbl.push_back('{0,1,32'h0040_0093,  0,0,0,32'h0,       0,32'h0,         0,32'h100,       NOP,           32'h8,         0});
        tbl.push_back('{0,0,32'h0,          0,0,1,32'h40,      1,32'h80,        1,32'h104,       32'h0040_0093, 32'h100,       1});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'h80,        32'h0040_0093, 32'h100,       1});
        tbl.push_back('{0,1,32'h0050_0093,  1,1,0,32'h0,       0,32'h0,         0,32'h80,        32'h0040_0093, 32'h100,       1});
        tbl.push_back('{0,0,32'h0,          0,0,0,32'h0,       0,32'h0,         0,32'h80,        NOP,           32'h100,       0});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       1,32'h200,       1,32'h84,        32'h0050_0093, 32'h80,        1});
        tbl.push_back('{0,1,32'hBAD0_0093,  0,0,0,32'h0,       0,32'h0,         0,32'h200,       32'h0050_0093, 32'h80,        1});
        tbl.push_back('{0,1,32'hBAD0_0093,  0,0,0,32'h0,       0,32'h0,         1,32'h200,       32'h0050_0093, 32'h80,        1});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'h200,       32'h0050_0093, 32'h80,        1});
        tbl.push_back('{0,1,32'h0060_0093,  1,0,0,32'h0,       0,32'h0,         0,32'h200,       32'h0050_0093, 32'h80,        1});
        tbl.push_back('{0,0,32'h0,          1,0,1,32'h300,     0,32'h0,         0,32'h200,       32'h0050_0093, 32'h80,        1});
        tbl.push_back('{0,0,32'h0,          0,0,0,32'h0,       1,32'hFFFF_FFFC, 1,32'h300,       32'h0050_0093, 32'h80,        1});
        tbl.push_back('{1,0,32'h0,          0,0,0,32'h0,       0,32'h0,         1,32'hFFFF_FFFC, 32'h0050_0093, 32'h80,        1});
        tbl.push_back('{0,1,32'h0070_0093,  0,0,0,32'h0,       0,32'h0,         0,32'hFFFF_FFFC, 32'h0050_0093, 32'h80,        1});

        // Expected values in row i describe the outputs after row i-1's edge;
        // shift so each row's check follows its own inputs.
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        chk_out("reset", 0, 32'h0, NOP, 32'h0, 0);
`ifdef IF_PERF_CNT_EN
        chk("reset.fetch_cnt", fetch_cnt, 32'd0);
        chk("reset.redirect_cnt", redirect_cnt, 32'd0);
`endif
        rst = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            imem_ready  = tbl[i].ready;
            imem_rvalid = tbl[i].rvalid;
            imem_rdata  = tbl[i].rdata;
            StallD      = tbl[i].stall;
            FlushD      = tbl[i].flush;
            JalD        = tbl[i].jal;
            JalTargetD  = tbl[i].jt;
            BrRedirectE = tbl[i].br;
            BrTargetE   = tbl[i].bt;
            @(negedge clk);
            if (i + 1 < tbl.size())
                chk_out($sformatf("tbl%0d", i), tbl[i+1].e_req, tbl[i+1].e_addr,
                        tbl[i+1].e_instr, tbl[i+1].e_pcd, tbl[i+1].e_valid);
        end
        chk_out("tbl_last", 1, 32'h0, 32'h0070_0093, 32'hFFFF_FFFC, 1);
`ifdef IF_PERF_CNT_EN
        chk("tbl.fetch_cnt", fetch_cnt, 32'd6);
        chk("tbl.redirect_cnt", redirect_cnt, 32'd5);
`endif

        // Asynchronous reset while a request is in flight.
        idle_inputs();
        imem_ready = 1;
        @(negedge clk);
        imem_ready = 0;
        chk("midwait.req", {31'd0, imem_req}, 32'd0);
        #2 rst = 1;
        #1;
        chk_out("async_rst", 0, 32'h0, NOP, 32'h0, 0);
`ifdef IF_PERF_CNT_EN
        chk("async_rst.fetch_cnt", fetch_cnt, 32'd0);
        chk("async_rst.redirect_cnt", redirect_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 3; k++) fetch_one(32'(k * 4), k);
`ifdef IF_PERF_CNT_EN
        chk("refetch.fetch_cnt", fetch_cnt, 32'd3);
        chk("refetch.redirect_cnt", redirect_cnt, 32'd0);
`endif

        // Randomised run against the behavioural model.
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        mpend = 0; mcnt = 0; maddr = 0;
        for (int c = 0; c < 3000; c++) begin
            chk_out($sformatf("rnd%0d", c), m_started && !m_busy && !m_hv,
                    m_pc, m_instr, m_pcd, m_valid);
`ifdef IF_PERF_CNT_EN
            chk($sformatf("rnd%0d.fetch_cnt", c), fetch_cnt, m_fc);
            chk($sformatf("rnd%0d.redirect_cnt", c), redirect_cnt, m_rc);
`endif
            StallD      = ($urandom % 4) == 0;
            FlushD      = ($urandom % 10) == 0;
            BrRedirectE = ($urandom % 12) == 0;
            JalD        = ($urandom % 12) == 0;
            BrTargetE   = rtgt();
            JalTargetD  = rtgt();
            imem_ready  = ($urandom % 3) != 0;
            if (mpend && mcnt == 0) begin
                imem_rvalid = 1;
                imem_rdata  = wordf(maddr);
            end else begin
                imem_rvalid = !mpend && (($urandom % 16) == 0);
                imem_rdata  = $urandom;
            end
            model_step();
            acc_mem = imem_req && imem_ready;
            saddr   = imem_addr;
            @(posedge clk);
            if (mpend && imem_rvalid) mpend = 0;
            else if (mpend) mcnt--;
            if (acc_mem) begin
                mpend = 1;
                mcnt  = $urandom_range(0, 2);
                maddr = saddr;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
